// File: rtl/fp_div16.sv
// fp_div16: multi-cycle FP16 divider (a / b) using restoring mantissa division,
// one quotient bit per clock, behind a start/done handshake.
// Flags layout: {overflow, zero, carry(always 0), negative}.
module fp_div16 #(
    parameter int          BIAS    = 15,
    parameter logic [15:0] NAN_VAL = 16'h7E00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] div16,
    output logic [3:0]  flags
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DIVIDE,
        NORM
    } state_t;

    state_t      state;
    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [11:0] rem;
    logic [10:0] mant_b;
    logic [11:0] q;
    logic [3:0]  cnt;

    logic [11:0]       rem_sub;
    logic [4:0]        exp_a;
    logic [4:0]        exp_b;
    logic              sign;
    logic              a_zero;
    logic              b_zero;
    logic signed [7:0] exp_raw;
    logic signed [7:0] exp_adj;
    logic [9:0]        frac;
    logic [15:0]       res;
    logic              res_ovf;
    logic              res_zero;

    // Trial subtraction for the current restoring-division step.
    always_comb begin
        rem_sub = rem - {1'b0, mant_b};
    end

    // Result selection from the latched operands and final quotient; special cases first.
    always_comb begin
        exp_a    = a_reg[14:10];
        exp_b    = b_reg[14:10];
        sign     = a_reg[15] ^ b_reg[15];
        a_zero   = (exp_a == 5'd0);
        b_zero   = (exp_b == 5'd0);
        exp_raw  = {3'b000, exp_a} - {3'b000, exp_b} + 8'(BIAS);
        if (q[11]) begin
            frac    = q[10:1];
            exp_adj = exp_raw;
        end else begin
            frac    = q[9:0];
            exp_adj = exp_raw - 8'sd1;
        end
        res      = 16'h0000;
        res_ovf  = 1'b0;
        res_zero = 1'b0;
        if (exp_a == 5'h1F || exp_b == 5'h1F) begin
            res      = NAN_VAL;
            res_zero = 1'b1;
        end else if (b_zero) begin
            if (a_zero) begin
                res      = NAN_VAL;
                res_zero = 1'b1;
            end else begin
                res     = {sign, 5'h1F, 10'h000};
                res_ovf = 1'b1;
            end
        end else if (a_zero) begin
            res      = {sign, 15'h0000};
            res_zero = 1'b1;
        end else if (exp_adj >= 8'sd31) begin
            res     = {sign, 5'h1F, 10'h000};
            res_ovf = 1'b1;
        end else if (exp_adj <= 8'sd0) begin
            res      = {sign, 15'h0000};
            res_zero = 1'b1;
        end else begin
            res = {sign, exp_adj[4:0], frac};
        end
    end

    // Control FSM and datapath: latch, decode, 12 division steps, then publish the result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            a_reg  <= 16'h0000;
            b_reg  <= 16'h0000;
            rem    <= 12'h000;
            mant_b <= 11'h000;
            q      <= 12'h000;
            cnt    <= 4'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            div16  <= 16'h0000;
            flags  <= 4'h0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        busy  <= 1'b1;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    rem    <= {1'b0, 1'b1, a_reg[9:0]};
                    mant_b <= {1'b1, b_reg[9:0]};
                    q      <= 12'h000;
                    cnt    <= 4'd0;
                    state  <= DIVIDE;
                end
                DIVIDE: begin
                    if (rem >= {1'b0, mant_b}) begin
                        q   <= {q[10:0], 1'b1};
                        rem <= rem_sub << 1;
                    end else begin
                        q   <= {q[10:0], 1'b0};
                        rem <= rem << 1;
                    end
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd11) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    div16 <= res;
                    flags <= {res_ovf, res_zero, 1'b0, res[15]};
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div16.sv
// tb_fp_div16: directed-vector bench for fp_div16 with a queue-based scoreboard.
// Stimulus pushes expected results; an independent monitor pops them on each done pulse.
module tb_fp_div16;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a     = 16'h0000;
    logic [15:0] b     = 16'h0000;
    logic        busy;
    logic        done;
    logic [15:0] div16;
    logic [3:0]  flags;

    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int busy_cnt   = 0;
    int done_total = 0;
    int done_before;

    typedef struct {
        logic [15:0] div;
        logic [3:0]  flg;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    typedef struct {
        string       name;
        logic [15:0] av;
        logic [15:0] bv;
        logic [15:0] ed;
        logic [3:0]  ef;
    } vec_t;

    vec_t vecs[9];

    fp_div16 dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .div16 (div16),
        .flags (flags)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Edge counter used to measure latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Issue one operation from a falling edge; record its expected result and done cycle.
    task automatic applyStimulus(input string name, input logic [15:0] av, input logic [15:0] bv,
                                 input logic [15:0] ed, input logic [3:0] ef);
        exp_t e;
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.div  = ed;
        e.flg  = ef;
        e.due  = cyc + 14;
        e.name = name;
        sb.push_back(e);
        start = 1'b0;
        a     = 16'($urandom());
        b     = 16'($urandom());
    endtask

    // Wait, with a cycle budget, for the scoreboard to drain; ends on a falling edge.
    task automatic waitIdle();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_done: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: on each done pulse pop the scoreboard and compare result, flags, latency, busy span.
    always @(negedge clk) begin
        if (!reset) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                done_total++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput({mon_e.name, "_div16"}, 32'(div16), 32'(mon_e.div));
                    checkOutput({mon_e.name, "_flags"}, 32'(flags), 32'(mon_e.flg));
                    checkOutput({mon_e.name, "_latency"}, 32'(cyc), 32'(mon_e.due));
                    checkOutput({mon_e.name, "_busy_cycles"}, 32'(busy_cnt), 32'd14);
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        vecs[0] = '{"t1_one_by_two",   16'h3C00, 16'h4000, 16'h3800, 4'b0000};
        vecs[1] = '{"t2_neg6_by_3",    16'hC600, 16'h4200, 16'hC000, 4'b0001};
        vecs[2] = '{"t2_one_by_1p5",   16'h3C00, 16'h3E00, 16'h3955, 4'b0000};
        vecs[3] = '{"t3_div_by_zero",  16'h4000, 16'h0000, 16'h7C00, 4'b1000};
        vecs[4] = '{"t3_zero_by_zero", 16'h0000, 16'h0000, 16'h7E00, 4'b0100};
        vecs[5] = '{"t3_inf_operand",  16'h7C00, 16'h3C00, 16'h7E00, 4'b0100};
        vecs[6] = '{"t4_overflow",     16'h7BFF, 16'h0400, 16'h7C00, 4'b1000};
        vecs[7] = '{"t4_underflow",    16'h0400, 16'h7BFF, 16'h0000, 4'b0100};
        vecs[8] = '{"t4_neg_zero",     16'h8000, 16'h3C00, 16'h8000, 4'b0101};

        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_div16", 32'(div16), 32'd0);
        checkOutput("reset_flags", 32'(flags), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].name, vecs[i].av, vecs[i].bv, vecs[i].ed, vecs[i].ef);
            waitIdle();
        end

        // Start pulse while busy must be ignored; start held in the done cycle is accepted.
        applyStimulus("t5_first", 16'h4000, 16'h3C00, 16'h4000, 4'b0000);
        repeat (3) @(negedge clk);
        a     = 16'h3C00;
        b     = 16'h4000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = 16'($urandom());
        b     = 16'($urandom());
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL t5_wait_done: got done=0, expected 1");
        end else begin
            applyStimulus("t5_back_to_back", 16'h4200, 16'h4000, 16'h3E00, 4'b0000);
        end
        waitIdle();

        // Reset asserted mid-division aborts the operation with no done pulse.
        a     = 16'h3C00;
        b     = 16'h4000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("t6_abort_busy", 32'(busy), 32'd0);
        checkOutput("t6_abort_done", 32'(done), 32'd0);
        checkOutput("t6_abort_div16", 32'(div16), 32'd0);
        checkOutput("t6_abort_flags", 32'(flags), 32'd0);
        done_before = done_total;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (25) @(negedge clk);
        checkOutput("t6_no_done", 32'(done_total), 32'(done_before));
        applyStimulus("t6_after_reset", 16'h3C00, 16'h4000, 16'h3800, 4'b0000);
        waitIdle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
